// File: rtl/dm_arbiter_8085.sv
// Data-memory port arbiter: pipeline MEM stage (CPU) vs debug/loader (DBG).
// Optional saturating statistics counters when DM_ARB_STATS_EN is defined.
module dm_arbiter_8085 #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_stall,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_wdata,
    output logic              dbg_gnt,
    output logic [7:0]        dbg_rdata,
    output logic              dbg_rvalid,
    output logic              dm_en,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [7:0]        dm_wdata,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]       cpu_stall_cnt,
    output logic [15:0]       dbg_grant_cnt,
    output logic [7:0]        forced_cnt,
`endif
    input  logic [7:0]        dm_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_OWN  = 2'd1,
        DBG_LOCK = 2'd2
    } state_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic [1:0] tag_q, tag_d;
    logic [7:0] cpu_hold_q, dbg_hold_q;
    logic       locked, forced;
    logic       cpu_win, dbg_win;

    // Winner selection; everything is gated off while reset is held low.
    always_comb begin
        locked  = (state_q == DBG_LOCK);
        forced  = reset && !locked && (starve_q == SMAX) && dbg_req;
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (!reset) begin
            cpu_win = 1'b0;
        end else if (locked && dbg_req) begin
            dbg_win = 1'b1;
        end else if (forced) begin
            dbg_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else if (dbg_req) begin
            dbg_win = 1'b1;
        end
    end

    always_comb begin
        dm_en    = cpu_win | dbg_win;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = 8'h00;
        if (dbg_win) begin
            dm_we    = dbg_we;
            dm_addr  = dbg_addr;
            dm_wdata = dbg_wdata;
        end else if (cpu_win) begin
            dm_we    = cpu_we;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_win;
    assign dbg_gnt   = dbg_win;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CPU_OWN: begin
                if (dbg_win && dbg_lock) begin
                    state_d = DBG_LOCK;
                end else if (cpu_win) begin
                    state_d = CPU_OWN;
                end else if (!cpu_req && !dbg_req) begin
                    state_d = IDLE;
                end
            end
            DBG_LOCK: begin
                if (!dbg_lock || !dbg_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!dbg_req || dbg_win) begin
            starve_d = 4'd0;
        end else if (starve_q >= SMAX) begin
            starve_d = SMAX;
        end else begin
            starve_d = starve_q + 4'd1;
        end
        tag_d = {cpu_win & ~cpu_we, dbg_win & ~dbg_we};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            tag_q      <= 2'b00;
            cpu_hold_q <= 8'h00;
            dbg_hold_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
            if (tag_q[1]) begin
                cpu_hold_q <= dm_rdata;
            end
            if (tag_q[0]) begin
                dbg_hold_q <= dm_rdata;
            end
        end
    end

    // Memory data is only valid in the cycle after the strobe; hold it after.
    assign cpu_rvalid = tag_q[1];
    assign dbg_rvalid = tag_q[0];
    assign cpu_rdata  = tag_q[1] ? dm_rdata : cpu_hold_q;
    assign dbg_rdata  = tag_q[0] ? dm_rdata : dbg_hold_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] grant_cnt_q;
    logic [7:0]  forced_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= 16'h0000;
            grant_cnt_q  <= 16'h0000;
            forced_cnt_q <= 8'h00;
        end else begin
            if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (dbg_gnt && (grant_cnt_q != 16'hFFFF)) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
            if (forced && (forced_cnt_q != 8'hFF)) begin
                forced_cnt_q <= forced_cnt_q + 8'd1;
            end
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
    assign dbg_grant_cnt = grant_cnt_q;
    assign forced_cnt    = forced_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter_8085.sv
// Testbench for dm_arbiter_8085: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_dm_arbiter_8085;

    localparam int SM = 4;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dbg_req, dbg_lock, dbg_we;
    logic [7:0] dbg_addr, dbg_wdata;
    logic       dbg_gnt, dbg_rvalid;
    logic [7:0] dbg_rdata;
    logic       dm_en, dm_we;
    logic [7:0] dm_addr, dm_wdata;
    logic [7:0] dm_rdata;
`ifdef DM_ARB_STATS_EN
    logic [15:0] cpu_stall_cnt, dbg_grant_cnt;
    logic [7:0]  forced_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dm_arbiter_8085 #(.ADDR_W(8), .STARVE_MAX(SM)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req),
        .dbg_lock(dbg_lock),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .dm_en(dm_en),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
`ifdef DM_ARB_STATS_EN
        .cpu_stall_cnt(cpu_stall_cnt),
        .dbg_grant_cnt(dbg_grant_cnt),
        .forced_cnt(forced_cnt),
`endif
        .dm_rdata(dm_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous data memory attached to the arbiter.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (dm_en) begin
            if (dm_we) mem[dm_addr] <= dm_wdata;
            else       dm_rdata <= mem[dm_addr];
        end
    end

    // Reference model state.
    logic [7:0] mm [256];
    bit         m_lock;
    int         m_starve;
    bit         m_cpend, m_dpend;
    logic [7:0] m_cdat, m_ddat, m_clast, m_dlast;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock   = 1'b0;
        m_starve = 0;
        m_cpend  = 1'b0;
        m_dpend  = 1'b0;
        m_clast  = 8'h00;
        m_dlast  = 8'h00;
    endtask

    task automatic chk_zero();
        chk("rst_stall", 16'(cpu_stall), 16'h0);
        chk("rst_gnt", 16'(dbg_gnt), 16'h0);
        chk("rst_en", 16'(dm_en), 16'h0);
        chk("rst_we", 16'(dm_we), 16'h0);
        chk("rst_addr", 16'(dm_addr), 16'h0);
        chk("rst_wdata", 16'(dm_wdata), 16'h0);
        chk("rst_crv", 16'(cpu_rvalid), 16'h0);
        chk("rst_crd", 16'(cpu_rdata), 16'h0);
        chk("rst_drv", 16'(dbg_rvalid), 16'h0);
        chk("rst_drd", 16'(dbg_rdata), 16'h0);
`ifdef DM_ARB_STATS_EN
        chk("rst_scnt", cpu_stall_cnt, 16'h0);
        chk("rst_gcnt", dbg_grant_cnt, 16'h0);
        chk("rst_fcnt", 16'(forced_cnt), 16'h0);
`endif
    endtask

    task automatic set_in(input bit cr, input bit cw, input logic [7:0] ca,
                          input logic [7:0] cd, input bit dr, input bit dl,
                          input bit dw, input logic [7:0] da,
                          input logic [7:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_lock = dl; dbg_we = dw;
        dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic do_reset();
        set_in(0, 0, 8'h0, 8'h0, 0, 0, 0, 8'h0, 8'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // One bus cycle: drive, check at negedge, advance model at posedge.
    task automatic cyc(input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit dr, input bit dl,
                       input bit dw, input logic [7:0] da,
                       input logic [7:0] dd, input bit rst_mid);
        bit dwin, cwin, frc, ewe;
        logic [7:0] ea, ewd;
        set_in(cr, cw, ca, cd, dr, dl, dw, da, dd);
        @(negedge clk);
        frc  = !m_lock && (m_starve == SM) && dr;
        dwin = (m_lock && dr) || frc || (!cr && dr);
        cwin = cr && !dwin;
        ewe  = dwin ? dw : (cwin ? cw : 1'b0);
        ea   = dwin ? da : (cwin ? ca : 8'h00);
        ewd  = dwin ? dd : (cwin ? cd : 8'h00);
        chk("stall", 16'(cpu_stall), 16'(cr && !cwin));
        chk("gnt", 16'(dbg_gnt), 16'(dwin));
        chk("dm_en", 16'(dm_en), 16'(dwin || cwin));
        chk("dm_we", 16'(dm_we), 16'(ewe));
        chk("dm_addr", 16'(dm_addr), 16'(ea));
        chk("dm_wdata", 16'(dm_wdata), 16'(ewd));
        chk("cpu_rvalid", 16'(cpu_rvalid), 16'(m_cpend));
        chk("cpu_rdata", 16'(cpu_rdata), 16'(m_cpend ? m_cdat : m_clast));
        chk("dbg_rvalid", 16'(dbg_rvalid), 16'(m_dpend));
        chk("dbg_rdata", 16'(dbg_rdata), 16'(m_dpend ? m_ddat : m_dlast));
        if (rst_mid) begin
            reset = 1'b0;
            #1;
            chk_zero();
            model_reset();
            @(posedge clk);
            #1 reset = 1'b1;
        end else begin
            @(posedge clk);
            if (m_cpend) m_clast = m_cdat;
            if (m_dpend) m_dlast = m_ddat;
            m_cpend = cwin && !cw;
            m_dpend = dwin && !dw;
            m_cdat  = mm[ca];
            m_ddat  = mm[da];
            if ((dwin || cwin) && ewe) mm[ea] = ewd;
            if (dr && !dwin) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
            else             m_starve = 0;
            m_lock = m_lock ? (dr && dl) : (dwin && dl);
            #1;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 8'h0, 8'h0, 0, 0, 0, 8'h0, 8'h0, 0);
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        do_reset();

        // Give every address used below a known value.
        for (int a = 0; a < 32; a++)
            cyc(1, 1, 8'(a), 8'(a * 7 + 3), 0, 0, 0, 8'h0, 8'h0, 0);

        // CPU only: write then read back.
        cyc(1, 1, 8'd11, 8'h5A, 0, 0, 0, 8'h0, 8'h0, 0);
        cyc(1, 0, 8'd11, 8'h00, 0, 0, 0, 8'h0, 8'h0, 0);
        idle();
        idle();

        // Contention from a clean starve counter.
        do_reset();
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 8'd11, 8'h0, 1, 0, 0, 8'd5, 8'h0, 0);
`ifdef DM_ARB_STATS_EN
        @(negedge clk);
        chk("stat_stall", cpu_stall_cnt, 16'd2);
        chk("stat_grant", dbg_grant_cnt, 16'd2);
        chk("stat_forced", 16'(forced_cnt), 16'd2);
`endif

        // Locked burst reached through a forced grant.
        for (int i = 0; i < SM; i++)
            cyc(1, 0, 8'd3, 8'h0, 1, 1, 1, 8'd16, 8'hA0, 0);
        cyc(1, 0, 8'd3, 8'h0, 1, 1, 1, 8'd16, 8'hA0, 0);
        cyc(1, 0, 8'd3, 8'h0, 1, 1, 1, 8'd17, 8'hA1, 0);
        cyc(1, 0, 8'd3, 8'h0, 1, 1, 1, 8'd18, 8'hA2, 0);
        cyc(1, 0, 8'd18, 8'h0, 0, 0, 0, 8'h0, 8'h0, 0);
        idle();

        // Back-to-back DBG then CPU reads.
        cyc(0, 0, 8'h0, 8'h0, 1, 0, 0, 8'd18, 8'h0, 0);
        cyc(1, 0, 8'd11, 8'h0, 0, 0, 0, 8'h0, 8'h0, 0);
        idle();
        idle();

        // Build up starvation, then reset between a read strobe and its edge.
        cyc(1, 0, 8'd2, 8'h0, 1, 0, 0, 8'd4, 8'h0, 0);
        cyc(1, 0, 8'd2, 8'h0, 1, 0, 0, 8'd4, 8'h0, 0);
        cyc(1, 0, 8'd11, 8'h0, 1, 0, 0, 8'd4, 8'h0, 1);
        idle();
        for (int i = 0; i < SM + 1; i++)
            cyc(1, 0, 8'd7, 8'h0, 1, 0, 0, 8'd9, 8'h0, 0);

        // Lock dropped by reset in the middle of a burst.
        cyc(0, 0, 8'h0, 8'h0, 1, 1, 1, 8'd20, 8'h33, 0);
        cyc(1, 0, 8'd1, 8'h0, 1, 1, 1, 8'd21, 8'h34, 1);
        cyc(1, 0, 8'd1, 8'h0, 1, 1, 1, 8'd22, 8'h35, 0);
        idle();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 31)), 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 31)), 8'($urandom),
                $urandom_range(0, 79) == 0);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
